// File: rtl/stream_carry_adder_pkg.sv
// Shared types and sizing for the stream carry adder and its prefix network.
package stream_carry_adder_pkg;

  localparam int unsigned DEFAULT_W = 16;

  // Index width of the prefix network, which spans W+1 positions (carry-in plus W bits)
  function automatic int unsigned net_idx_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned NET_IDX_W = net_idx_w(DEFAULT_W);

  typedef enum logic {
    CH_FIRST = 1'b0,
    CH_MID   = 1'b1
  } chain_state_t;

  typedef struct packed {
    logic first;
    logic last;
    logic sub;
  } beat_ctl_t;

endpackage

// File: rtl/brent_kung.sv
// Brent-Kung parallel prefix network over N+1 (generate, propagate) positions.
// carry[i] is the group generate of positions 0..i.
module brent_kung
  import stream_carry_adder_pkg::*;
#(
  parameter int unsigned N  = DEFAULT_W,
  parameter int unsigned IW = NET_IDX_W
) (
  input  logic [N:0] gen,
  input  logic [N:0] prop,
  output logic [N:0] carry
);

  localparam int unsigned M      = N + 1;
  localparam int unsigned LEVELS = $clog2(M);

  logic [N:0] gt;
  logic [N:0] pt;

  // Up-sweep builds power-of-two spans; down-sweep fills the remaining prefixes
  always_comb begin
    gt = gen;
    pt = prop;
    for (int lvl = 0; lvl < int'(LEVELS); lvl++) begin
      for (int i = (2 << lvl) - 1; i < int'(M); i += (2 << lvl)) begin
        gt[IW'(i)] = gt[IW'(i)] | (pt[IW'(i)] & gt[IW'(i - (1 << lvl))]);
        pt[IW'(i)] = pt[IW'(i)] & pt[IW'(i - (1 << lvl))];
      end
    end
    for (int lvl = int'(LEVELS) - 1; lvl >= 0; lvl--) begin
      for (int i = (3 << lvl) - 1; i < int'(M); i += (2 << lvl)) begin
        gt[IW'(i)] = gt[IW'(i)] | (pt[IW'(i)] & gt[IW'(i - (1 << lvl))]);
        pt[IW'(i)] = pt[IW'(i)] & pt[IW'(i - (1 << lvl))];
      end
    end
    carry = gt;
  end

endmodule

// File: rtl/stream_carry_adder.sv
// Two-stage streaming multi-word adder/subtractor; carries chain across beats
// of one operation, least-significant word first.
module stream_carry_adder
  import stream_carry_adder_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_cout,
  output logic         out_ovf
);

  chain_state_t chain_q;
  chain_state_t chain_d;
  logic         beat_first_c;
  logic         beat_sub_c;
  logic         sub_q;
  logic [W-1:0] b_eff_c;

  logic         s2_adv_c;
  logic         s1_adv_c;
  logic         in_xfer_c;

  logic         s1_valid;
  logic [W-1:0] s1_g;
  logic [W-1:0] s1_p;
  beat_ctl_t    s1_ctl;

  logic         carry_q;
  logic         cin_c;
  logic [W:0]   c_c;

  assign s2_adv_c  = !out_valid || out_ready;
  assign s1_adv_c  = !s1_valid || s2_adv_c;
  assign in_ready  = rst_n && s1_adv_c;
  assign in_xfer_c = in_valid && in_ready;

  // Chain tracking: after a last beat (or reset) the next beat opens a new operation
  always_ff @(posedge clk) begin
    if (!rst_n) chain_q <= CH_FIRST;
    else        chain_q <= chain_d;
  end

  always_comb begin
    chain_d = chain_q;
    if (in_xfer_c) chain_d = in_last ? CH_FIRST : CH_MID;
  end

  always_comb begin
    beat_first_c = in_first;
    if (chain_q == CH_FIRST) beat_first_c = 1'b1;
    beat_sub_c = beat_first_c ? in_sub : sub_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          sub_q <= 1'b0;
    else if (in_xfer_c && beat_first_c)  sub_q <= in_sub;
  end

  assign b_eff_c = beat_sub_c ? ~in_b : in_b;

  // Stage 1: per-bit generate/propagate plus beat control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_ctl   <= '0;
    end else if (s1_adv_c) begin
      s1_valid <= in_xfer_c;
      if (in_xfer_c) begin
        s1_g   <= in_a & b_eff_c;
        s1_p   <= in_a ^ b_eff_c;
        s1_ctl <= '{first: beat_first_c, last: in_last, sub: beat_sub_c};
      end
    end
  end

  assign cin_c = s1_ctl.first ? s1_ctl.sub : carry_q;

  brent_kung #(
    .N  (W),
    .IW (net_idx_w(W))
  ) u_bk (
    .gen   ({s1_g, cin_c}),
    .prop  ({s1_p, 1'b0}),
    .carry (c_c)
  );

  // Stage 2: result straight into the output registers; chain carry follows loads only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      carry_q   <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= s1_p ^ c_c[W-1:0];
        out_last <= s1_ctl.last;
        out_cout <= s1_ctl.last & c_c[W];
        out_ovf  <= s1_ctl.last & (c_c[W] ^ c_c[W-1]);
        carry_q  <= c_c[W];
      end
    end
  end

endmodule

// File: tb/tb_stream_carry_adder.sv
// Scoreboard bench for stream_carry_adder: directed corner cases plus a long
// randomized run with backpressure against a word-serial arithmetic model.
module tb_stream_carry_adder;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         last;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_first;
  logic         in_last;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         out_ovf;

  stream_carry_adder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  res_t exp_q[$];
  res_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_first_next = 1'b1;
  bit   m_sub = 1'b0;
  bit   m_carry = 1'b0;
  bit   held = 1'b0;
  res_t held_r;
  bit   bp_en = 1'b0;
  int   acc_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each operation is one long integer processed a word at a time
  task automatic monitor();
    res_t         act;
    res_t         e;
    bit           first;
    logic [W-1:0] beff;
    logic [W:0]   t;
    forever begin
      @(negedge clk);
      act = {out_sum, out_last, out_cout, out_ovf};
      if (!rst_n) begin
        exp_q.delete();
        m_first_next = 1'b1;
        m_carry      = 1'b0;
        held         = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_data", 64'(act), 64'(held_r));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got beat 0x%0h expected none", act);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", 64'(act), 64'(e));
            obs_q.push_back(act);
          end
        end
        held   = out_valid && !out_ready;
        held_r = act;
        if (in_valid && in_ready) begin
          first = in_first || m_first_next;
          if (first) begin
            m_sub   = in_sub;
            m_carry = in_sub;
          end
          beff  = m_sub ? ~in_b : in_b;
          t     = {1'b0, in_a} + {1'b0, beff} + {{W{1'b0}}, m_carry};
          e.sum  = t[W-1:0];
          e.last = in_last;
          e.cout = in_last & t[W];
          e.ovf  = in_last & (in_a[W-1] == beff[W-1]) & (t[W-1] != in_a[W-1]);
          m_carry      = t[W];
          m_first_next = in_last;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic accept();
    bit ok;
    ok = 1'b0;
    acc_wait = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      acc_wait++;
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic f, input logic l, input logic s);
    in_a     = a;
    in_b     = b;
    in_first = f;
    in_last  = l;
    in_sub   = s;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic f, input logic l, input logic s);
    drive(a, b, f, l, s);
    accept();
  endtask

  task automatic drain();
    bp_en     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [W-1:0] sum,
                         input logic l, input logic c, input logic o);
    res_t r;
    r = {sum, l, c, o};
    if (obs_q.size() <= idx) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d beats expected beat %0d", name, obs_q.size(), idx);
    end else begin
      chk(name, 64'(obs_q[idx]), 64'(r));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_word", 64'({out_sum, out_last, out_cout, out_ovf}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'(1));
    tick();

    // Single-beat add wraps to zero with carry-out; two-cycle latency
    obs_q.delete();
    send(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("latency_c1_valid", 64'(out_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("latency_c2_valid", 64'(out_valid), 64'(1));
    tick();
    drain();
    chk_obs("add_ffff_1", 0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Two-beat add, carry propagates; back-to-back acceptance
    obs_q.delete();
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("b2b_accept_wait", 64'(acc_wait), 64'(0));
    drain();
    chk_obs("chain2_b0", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_obs("chain2_b1", 1, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Subtraction corners
    obs_q.delete();
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    drain();
    chk_obs("sub_5_7", 0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    chk_obs("sub_8000_1", 1, 16'h7FFF, 1'b1, 1'b1, 1'b1);

    // Latched sub survives in_sub=0 mid-op; next beat after last is a first beat
    obs_q.delete();
    send(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 1'b1, 1'b1);
    drain();
    chk_obs("sub_latch_b0", 0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk_obs("sub_latch_b1", 1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    chk_obs("implicit_first", 2, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // in_first mid-operation restarts with fresh carry-in
    obs_q.delete();
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    send(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0);
    drain();
    chk_obs("restart_b1", 1, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Backpressure: two beats held, input stalls, outputs stable
    obs_q.delete();
    out_ready = 1'b0;
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      tick();
    end
    out_ready = 1'b1;
    accept();
    chk("release_accept_wait", 64'(acc_wait), 64'(0));
    drain();
    chk_obs("bp_b0", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_obs("bp_b1", 1, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_obs("bp_b2", 2, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Reset during beat 2 of 3 discards the chain
    send(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    tick();
    obs_q.delete();
    send(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0);
    drain();
    chk_obs("post_rst_beat", 0, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Randomized stream with backpressure
    bp_en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(W'($urandom), W'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_carry_adder.md
STREAM_CARRY_ADDER -- requirements
Module: stream_carry_adder

Interface
REQ-001 Parameter W, default 16, sets the operand and sum word width in bits; legal range is 4..64.
REQ-002 clk  input  1  is the single clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  is the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  indicates that the input beat is valid.
REQ-005 in_ready  output  1  indicates that the block accepts the input beat; a transfer occurs when in_valid and in_ready are both high.
REQ-006 in_a, in_b  input  W each  carry the operand words of the current beat, least-significant word first.
REQ-007 in_first, in_last  input  1 each  mark the first and last beat of a multi-word operation.
REQ-008 in_sub  input  1  selects subtraction (a-b) when high; it is sampled only on a first beat.
REQ-009 out_valid, out_ready  output/input  1 each  form the result handshake.
REQ-010 out_sum  output  W  carries the sum/difference word.
REQ-011 out_last  output  1  repeats in_last for the beat.
REQ-012 out_cout, out_ovf  output  1 each  carry the unsigned carry-out and the signed overflow; both are valid only when out_last is high and are 0 otherwise.

Function
REQ-013 Stage 1 shall register g=a&b' and p=a^b', where b'=in_b when add and b'=~in_b when sub, together with first, last and sub.
REQ-014 Stage 2 shall compute the carries with the prefix carry network, with bit 0 = beat carry-in; out_sum = p ^ c[W-1:0].
REQ-015 The stage 2 result shall be registered directly into the out_* signals.
REQ-016 The beat carry-in shall equal sub on a first beat, and the stored chain carry c[W] of the previous beat otherwise.
REQ-017 The chain carry register shall update only when stage 2 loads a beat.
REQ-018 Latency shall be 2 cycles from input transfer to out_valid when out_ready stays high, with throughput of one beat per cycle.
REQ-019 Stage 2 shall advance when !out_valid || out_ready.
REQ-020 Stage 1 shall advance when its register is empty or stage 2 advances.
REQ-021 in_ready shall equal the stage 1 advance condition, with no combinational path from in_valid to in_ready.
REQ-022 While out_valid is high and out_ready is low, all out_* signals shall hold stable.
REQ-023 On the last beat, out_cout = c[W] and out_ovf = c[W] ^ c[W-1].
REQ-024 A beat arriving after a last beat shall be treated as a first beat even if in_first is low.
REQ-025 in_first asserted mid-operation shall abandon the old chain and restart, with no error output.
REQ-026 The sub value latched on the first beat shall apply to every beat through the last; in_sub on other beats is ignored.
REQ-027 A single beat with in_first and in_last both high is a complete W-bit operation.
REQ-028 When an input transfer and an output transfer occur in the same cycle, both shall complete with no bubble.

Reset
REQ-029 While rst_n is low: out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, the stage 1 valid flag=0, the chain carry=0, and the chain state is "expect first".
REQ-030 While rst_n is low, in_ready shall be 0; it shall be 1 in the first cycle after rst_n goes high.
REQ-031 Reset mid-operation shall discard in-flight beats, and the next accepted beat shall be treated as a first beat.

Structure
REQ-032 A shared package shall hold the default W and a localparam for the network index width (W).
REQ-033 The sub-module shall be the existing brent_kung prefix network, instantiated with N=W, fed {g,cin} / {p,0} vectors; all other logic is in this module.

Verification
REQ-034 With W=16, a single beat a=0xFFFF, b=0x0001, add, first+last -> 2 cycles later sum=0x0000, cout=1, ovf=0.
REQ-035 A two-beat add with beat0 a=0xFFFF, b=0x0001 and beat1 a=0x0000, b=0x0000 -> sums 0x0000 then 0x0001, last beat cout=0, ovf=0.
REQ-036 Sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-037 A 3-beat stream with out_ready held low for 5 cycles -> 2 beats are held, in_ready=0, and out_* stay stable; on release, order and chained carries are correct.
REQ-038 rst_n low for 1 cycle during beat 2 of 3 -> out_valid=0 the next cycle; a following beat with in_first=0, a=0x0001, b=0x0001 gives sum 0x0002 with carry-in 0.
REQ-039 A random bench of 10k beats with random first/last/sub and random backpressure shall match a bignum reference model on every beat.
